rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DW, default 16: register data width.
REQ-002 Parameter AW, default 4: register address width; register count is 2^AW.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 alu_req  input  1  ALU writeback request.
REQ-006 alu_addr  input  AW  ALU destination register.
REQ-007 alu_data  input  DW  ALU result.
REQ-008 alu_gnt  output  1  ALU request accepted this cycle (combinational).
REQ-009 mem_req  input  1  load writeback request.
REQ-010 mem_addr  input  AW  load destination register.
REQ-011 mem_data  input  DW  load data.
REQ-012 mem_gnt  output  1  load request accepted this cycle (combinational).
REQ-013 clr_req  input  1  single-cycle pulse requesting a full register-file clear.
REQ-014 busy  output  1  clear sweep in progress.
REQ-015 rf_we  output  1  register-file write enable (registered).
REQ-016 rf_waddr  output  AW  register-file write address (registered).
REQ-017 rf_wdata  output  DW  register-file write data (registered).

Function
REQ-018 FSM SHALL have two states: CLEAR and RUN; busy SHALL equal (state==CLEAR).
REQ-019 In CLEAR, each edge SHALL register rf_we=1, rf_waddr=cnt, rf_wdata=0, then increment cnt; the edge with cnt==2^AW-1 SHALL move to RUN and reset cnt to 0.
REQ-020 A sweep SHALL take exactly 2^AW cycles (16 at default) and write addresses 0..2^AW-1 in ascending order.
REQ-021 In CLEAR, alu_gnt and mem_gnt SHALL be 0; requesters hold their requests until granted.
REQ-022 In RUN, at most one grant SHALL be asserted per cycle; a lone request SHALL be granted in the same cycle.
REQ-023 A granted request SHALL appear on rf_we/rf_waddr/rf_wdata on the next edge (latency 1 cycle); rf_we SHALL be 0 after any edge with no grant.
REQ-024 A granted write to address 0 SHALL consume the grant but register rf_we=0 (R0 is hardwired zero).
REQ-025 In RUN, clr_req=1 SHALL take priority over both requests: no grant that cycle, rf_we=0 on the next edge, and move to CLEAR with cnt=0.
REQ-026 clr_req during CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-027 Conflict resolution (both requests in RUN, no clr_req) SHALL follow REQ-033/REQ-034.

Reset
REQ-028 While rst=1: state=CLEAR, cnt=0, busy=1, rf_we=0, rf_waddr=0, rf_wdata=0, alu_gnt=0, mem_gnt=0, last-grant pointer=ALU.
REQ-029 The first rising edge after rst falls SHALL perform the sweep write to address 0.
REQ-030 Reset asserted mid-sweep or mid-write SHALL abort it; the sweep SHALL restart from address 0 after release.

Configuration
REQ-031 Macro RF_WB_ARB_RR_EN SHALL select the conflict policy.
REQ-032 Exactly one policy is compiled in; the interface SHALL be identical in both builds.
REQ-033 With RF_WB_ARB_RR_EN defined: on conflict, grant the requester not granted most recently; the pointer SHALL update on every grant.
REQ-034 Without RF_WB_ARB_RR_EN: on conflict, mem SHALL always win (fixed priority MEM > ALU); the pointer is absent.

Verification
REQ-035 Release reset, no requests -> busy=1 for 16 cycles, rf_we=1 with rf_waddr 0..15 and rf_wdata=0, busy=0 from cycle 17.
REQ-036 RUN, alu_req=1 addr=3 data=0x1234 -> alu_gnt=1 same cycle, next cycle rf_we=1 rf_waddr=3 rf_wdata=0x1234.
REQ-037 RUN, both request for 4 cycles (alu addr 1 data 0xAAAA, mem addr 2 data 0x5555) -> RR build: grants alternate M,A,M,A (pointer=ALU after reset); fixed build: mem_gnt=1 all 4 cycles, alu_gnt=0.
REQ-038 RUN, mem_req addr=0 data=0xFFFF -> mem_gnt=1, next cycle rf_we=0.
REQ-039 RUN, clr_req=1 with alu_req=1 -> alu_gnt=0, busy=1 next cycle, 16 zero writes, then alu_gnt=1 in the first RUN cycle.
REQ-040 rst pulsed at sweep address 7 -> outputs return to reset values immediately; after release the sweep restarts at address 0 and runs 16 cycles.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU/load arbitration plus a power-on/on-demand zero sweep.
// Conflict policy: define RF_WB_ARB_RR_EN for round-robin, otherwise fixed priority MEM > ALU.
module rf_wb_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_req,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_gnt,
    input  logic          mem_req,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_gnt,
    input  logic          clr_req,
    output logic          busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;

`ifdef RF_WB_ARB_RR_EN
    // Last-granted pointer: 0 = ALU, 1 = MEM.
    localparam logic PTR_ALU = 1'b0;
    localparam logic PTR_MEM = 1'b1;
    logic ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PTR_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (alu_gnt) begin
            ptr_d = PTR_ALU;
        end else if (mem_gnt) begin
            ptr_d = PTR_MEM;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Grants are only issued in RUN and yield to a clear request.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (state_q == RUN && !clr_req) begin
            if (alu_req && mem_req) begin
`ifdef RF_WB_ARB_RR_EN
                if (ptr_q == PTR_ALU) begin
                    mem_gnt = 1'b1;
                end else begin
                    alu_gnt = 1'b1;
                end
`else
                mem_gnt = 1'b1;
`endif
            end else begin
                alu_gnt = alu_req;
                mem_gnt = mem_req;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (state_q)
            CLEAR: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (alu_gnt) begin
                    // R0 is hardwired zero: the grant is consumed but nothing is written.
                    rf_we_d    = (alu_addr != '0);
                    rf_waddr_d = alu_addr;
                    rf_wdata_d = alu_data;
                end else if (mem_gnt) begin
                    rf_we_d    = (mem_addr != '0);
                    rf_waddr_d = mem_addr;
                    rf_wdata_d = mem_data;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, sweep, grants, R0 drop, clear priority, async reset abort.
module tb_rf_wb_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          alu_req;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_gnt;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_gnt;
    logic          clr_req;
    logic          busy;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    int checks = 0;
    int passed = 0;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_req  (alu_req),
        .alu_addr (alu_addr),
        .alu_data (alu_data),
        .alu_gnt  (alu_gnt),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_gnt  (mem_gnt),
        .clr_req  (clr_req),
        .busy     (busy),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a full 16-write zero sweep starting at the next edge.
    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_agnt"}, 32'(alu_gnt), 32'd0);
            tick();
            chk({tag, "_we"}, 32'(rf_we), 32'd1);
            chk({tag, "_waddr"}, 32'(rf_waddr), 32'(i));
            chk({tag, "_wdata"}, 32'(rf_wdata), 32'd0);
        end
        chk({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        alu_req  = 1'b1;
        alu_addr = 4'd3;
        alu_data = 16'h1111;
        mem_req  = 1'b1;
        mem_addr = 4'd4;
        mem_data = 16'h2222;
        clr_req  = 1'b0;

        // Reset state, with both requests pending.
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_agnt", 32'(alu_gnt), 32'd0);
        chk("rst_mgnt", 32'(mem_gnt), 32'd0);
        alu_req = 1'b0;
        mem_req = 1'b0;
        rst     = 1'b0;

        // Power-on sweep.
        sweep("sweep0");
        tick();
        chk("idle_we", 32'(rf_we), 32'd0);

        // Lone ALU write.
        alu_req  = 1'b1;
        alu_addr = 4'd3;
        alu_data = 16'h1234;
        #1;
        chk("alu_gnt", 32'(alu_gnt), 32'd1);
        chk("alu_mgnt", 32'(mem_gnt), 32'd0);
        tick();
        alu_req = 1'b0;
        chk("alu_we", 32'(rf_we), 32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd3);
        chk("alu_wdata", 32'(rf_wdata), 32'h1234);
        tick();
        chk("alu_we_off", 32'(rf_we), 32'd0);

        // Four cycles of conflict.
        alu_req  = 1'b1;
        alu_addr = 4'd1;
        alu_data = 16'hAAAA;
        mem_req  = 1'b1;
        mem_addr = 4'd2;
        mem_data = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            logic exp_mem;
`ifdef RF_WB_ARB_RR_EN
            exp_mem = (k % 2 == 0);
`else
            exp_mem = 1'b1;
`endif
            #1;
            chk("conf_mgnt", 32'(mem_gnt), 32'(exp_mem));
            chk("conf_agnt", 32'(alu_gnt), 32'(!exp_mem));
            tick();
            chk("conf_we", 32'(rf_we), 32'd1);
            chk("conf_waddr", 32'(rf_waddr), exp_mem ? 32'd2 : 32'd1);
            chk("conf_wdata", 32'(rf_wdata), exp_mem ? 32'h5555 : 32'hAAAA);
        end
        alu_req = 1'b0;
        mem_req = 1'b0;
        tick();
        chk("conf_we_off", 32'(rf_we), 32'd0);

        // Load to R0: grant consumed, no write.
        mem_req  = 1'b1;
        mem_addr = 4'd0;
        mem_data = 16'hFFFF;
        #1;
        chk("r0_mgnt", 32'(mem_gnt), 32'd1);
        tick();
        mem_req = 1'b0;
        chk("r0_we", 32'(rf_we), 32'd0);

        // Single conflict right after a MEM grant.
        alu_req  = 1'b1;
        alu_addr = 4'd6;
        alu_data = 16'h0606;
        mem_req  = 1'b1;
        mem_addr = 4'd7;
        mem_data = 16'h0707;
        #1;
`ifdef RF_WB_ARB_RR_EN
        chk("conf2_agnt", 32'(alu_gnt), 32'd1);
        chk("conf2_mgnt", 32'(mem_gnt), 32'd0);
`else
        chk("conf2_agnt", 32'(alu_gnt), 32'd0);
        chk("conf2_mgnt", 32'(mem_gnt), 32'd1);
`endif
        tick();
        alu_req = 1'b0;
        mem_req = 1'b0;
`ifdef RF_WB_ARB_RR_EN
        chk("conf2_waddr", 32'(rf_waddr), 32'd6);
`else
        chk("conf2_waddr", 32'(rf_waddr), 32'd7);
`endif

        // Clear beats a pending ALU request; a second clear mid-sweep is ignored.
        alu_req  = 1'b1;
        alu_addr = 4'd9;
        alu_data = 16'h9999;
        clr_req  = 1'b1;
        #1;
        chk("clr_agnt", 32'(alu_gnt), 32'd0);
        chk("clr_mgnt", 32'(mem_gnt), 32'd0);
        tick();
        clr_req = 1'b0;
        chk("clr_we", 32'(rf_we), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            clr_req = (i == 4);
            chk("clr_sw_agnt", 32'(alu_gnt), 32'd0);
            tick();
            chk("clr_sw_we", 32'(rf_we), 32'd1);
            chk("clr_sw_waddr", 32'(rf_waddr), 32'(i));
            chk("clr_sw_wdata", 32'(rf_wdata), 32'd0);
        end
        clr_req = 1'b0;
        chk("clr_done", 32'(busy), 32'd0);
        chk("clr_agnt_run", 32'(alu_gnt), 32'd1);
        tick();
        alu_req = 1'b0;
        chk("clr_alu_we", 32'(rf_we), 32'd1);
        chk("clr_alu_waddr", 32'(rf_waddr), 32'd9);
        chk("clr_alu_wdata", 32'(rf_wdata), 32'h9999);

        // Asynchronous reset in the middle of a sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_waddr", 32'(rf_waddr), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(rf_we), 32'd0);
        chk("arst_waddr", 32'(rf_waddr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b0;
        sweep("sweep1");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
